// File: rtl/stump_ctrl_seq_pkg.sv
// Shared definitions for the Stump control sequencer: state codes, opcodes
// and branch condition codes.
package stump_ctrl_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_HALT    = 2'b11
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    typedef enum logic [3:0] {
        CC_AL = 4'd0,  CC_NV = 4'd1,  CC_HI = 4'd2,  CC_LS = 4'd3,
        CC_CC = 4'd4,  CC_CS = 4'd5,  CC_NE = 4'd6,  CC_EQ = 4'd7,
        CC_VC = 4'd8,  CC_VS = 4'd9,  CC_PL = 4'd10, CC_MI = 4'd11,
        CC_GE = 4'd12, CC_LT = 4'd13, CC_GT = 4'd14, CC_LE = 4'd15
    } cond_e;

endpackage

// File: rtl/stump_ctrl_seq_branch_eval.sv
// Branch condition evaluator: decides whether a Bcc is taken from the
// condition field and the {N,Z,V,C} flags.
module stump_branch_eval
    import stump_ctrl_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       taken
);

    logic n_flag, z_flag, v_flag, c_flag;

    assign n_flag = cc[3];
    assign z_flag = cc[2];
    assign v_flag = cc[1];
    assign c_flag = cc[0];

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            CC_AL: taken = 1'b1;
            CC_NV: taken = 1'b0;
            CC_HI: taken = ~(c_flag | z_flag);
            CC_LS: taken = c_flag | z_flag;
            CC_CC: taken = ~c_flag;
            CC_CS: taken = c_flag;
            CC_NE: taken = ~z_flag;
            CC_EQ: taken = z_flag;
            CC_VC: taken = ~v_flag;
            CC_VS: taken = v_flag;
            CC_PL: taken = ~n_flag;
            CC_MI: taken = n_flag;
            CC_GE: taken = v_flag ~^ n_flag;
            CC_LT: taken = v_flag ^ n_flag;
            CC_GT: taken = ~((v_flag ^ n_flag) | z_flag);
            CC_LE: taken = (v_flag ^ n_flag) | z_flag;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_ctrl_seq.sv
// Stump control unit: FSM state register, memory wait-state counter with
// bus timeout, halt state and the ir/cc control decoder.
module stump_ctrl_seq
    import stump_ctrl_seq_pkg::*;
#(
    parameter int              IR_W      = 16,
    parameter int              RA_W      = 3,
    parameter int              TMO_W     = 4,
    parameter logic [IR_W-1:0] HALT_INSN = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] ir,
    input  logic [3:0]      cc,
    input  logic            mem_ack,
    output logic [1:0]      state,
    output logic            fetch,
    output logic            execute,
    output logic            memory,
    output logic            ir_load,
    output logic            ext_op,
    output logic            reg_write,
    output logic            opB_mux_sel,
    output logic            cc_en,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [RA_W-1:0] dest,
    output logic [RA_W-1:0] srcA,
    output logic [RA_W-1:0] srcB,
    output logic [1:0]      shift_op,
    output logic [2:0]      alu_func,
    output logic            bus_err
);

    localparam logic [RA_W-1:0]  PC_REG  = '1;
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_err_q, bus_err_d;

    logic [2:0] opcode;
    logic       type_bit;
    logic       taken;
    logic       timeout;

    assign opcode   = ir[IR_W-1 -: 3];
    assign type_bit = ir[IR_W-4];
    // The terminal-count cycle only times out if the ack does not arrive in it.
    assign timeout  = (wait_cnt_q == TMO_MAX) && !mem_ack;

    stump_branch_eval u_branch_eval (
        .cond  (ir[11:8]),
        .cc    (cc),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        bus_err_d   = bus_err_q;
        ir_load     = 1'b0;
        ext_op      = 1'b0;
        reg_write   = 1'b0;
        opB_mux_sel = 1'b0;
        cc_en       = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        dest        = '0;
        srcA        = '0;
        srcB        = '0;
        shift_op    = 2'b00;
        alu_func    = OP_ADD;

        case (state_q)
            ST_FETCH: begin
                mem_ren   = 1'b1;
                srcA      = PC_REG;
                dest      = PC_REG;
                alu_func  = OP_ADD;
                reg_write = mem_ack;
                ir_load   = mem_ack;
                if (mem_ack) begin
                    state_d = ST_EXECUTE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_EXECUTE: begin
                if (ir == HALT_INSN) begin
                    state_d = ST_HALT;
                end else begin
                    state_d   = ST_FETCH;
                    dest      = RA_W'(ir[10:8]);
                    srcA      = RA_W'(ir[7:5]);
                    srcB      = RA_W'(ir[4:2]);
                    shift_op  = ir[1:0];
                    alu_func  = opcode;
                    cc_en     = ir[11];
                    reg_write = 1'b1;
                    if (type_bit) begin
                        opB_mux_sel = 1'b1;
                        ext_op      = 1'b1;
                        srcB        = '0;
                        shift_op    = 2'b00;
                    end
                    case (opcode)
                        OP_LDST: begin
                            state_d   = ST_MEMORY;
                            reg_write = 1'b0;
                            cc_en     = 1'b0;
                        end
                        OP_BCC: begin
                            dest        = PC_REG;
                            srcA        = PC_REG;
                            srcB        = '0;
                            shift_op    = 2'b00;
                            ext_op      = 1'b1;
                            opB_mux_sel = 1'b1;
                            cc_en       = 1'b0;
                            reg_write   = taken;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MEMORY: begin
                if (ir[11]) begin
                    mem_wen = 1'b1;
                    srcA    = RA_W'(ir[10:8]);
                end else begin
                    mem_ren   = 1'b1;
                    dest      = RA_W'(ir[10:8]);
                    reg_write = mem_ack;
                end
                if (mem_ack) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: ;
        endcase

        // A reset edge drops any access in flight, so nothing may be written in that cycle.
        if (rst) begin
            reg_write = 1'b0;
            cc_en     = 1'b0;
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
            ir_load   = 1'b0;
        end
    end

    assign state   = state_q;
    assign fetch   = (state_q == ST_FETCH);
    assign execute = (state_q == ST_EXECUTE);
    assign memory  = (state_q == ST_MEMORY);
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_stump_ctrl_seq.sv
// Directed bench for stump_ctrl_seq: fetch/execute flow, loads with wait
// states, branches, bus timeout, halt and reset during a store.
module tb_stump_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  cc;
    logic        mem_ack;
    logic [1:0]  state;
    logic        fetch, execute, memory;
    logic        ir_load, ext_op, reg_write, opB_mux_sel, cc_en, mem_ren, mem_wen;
    logic [2:0]  dest, srcA, srcB;
    logic [1:0]  shift_op;
    logic [2:0]  alu_func;
    logic        bus_err;

    logic [4:0]  en;
    logic [2:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    assign en    = {reg_write, cc_en, mem_ren, mem_wen, ir_load};
    assign flags = {fetch, execute, memory};

    stump_ctrl_seq dut (
        .clk         (clk),
        .rst         (rst),
        .ir          (ir),
        .cc          (cc),
        .mem_ack     (mem_ack),
        .state       (state),
        .fetch       (fetch),
        .execute     (execute),
        .memory      (memory),
        .ir_load     (ir_load),
        .ext_op      (ext_op),
        .reg_write   (reg_write),
        .opB_mux_sel (opB_mux_sel),
        .cc_en       (cc_en),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .dest        (dest),
        .srcA        (srcA),
        .srcB        (srcB),
        .shift_op    (shift_op),
        .alu_func    (alu_func),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst     = 1'b1;
        ir      = 16'h0000;
        cc      = 4'b0000;
        mem_ack = 1'b0;
        tick();
        tick();
        #1;
        check("rst_state",   32'(state),   32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_en_off",  32'(en),      32'h0);

        // Fetch waiting for memory
        rst = 1'b0;
        #1;
        check("fetch_flags", 32'(flags),     32'b100);
        check("fetch_ren",   32'(mem_ren),   32'h1);
        check("fetch_nowr",  32'(reg_write), 32'h0);
        check("fetch_srcA",  32'(srcA),      32'h7);
        check("fetch_dest",  32'(dest),      32'h7);

        // ADD r1,r2,r3 with flag update
        ir      = 16'h094C;
        mem_ack = 1'b1;
        #1;
        check("fetch_ack_wr",   32'(reg_write), 32'h1);
        check("fetch_ack_irld", 32'(ir_load),   32'h1);
        tick();
        #1;
        check("add_state", 32'(state),     32'h1);
        check("add_flags", 32'(flags),     32'b010);
        check("add_dest",  32'(dest),      32'h1);
        check("add_srcA",  32'(srcA),      32'h2);
        check("add_srcB",  32'(srcB),      32'h3);
        check("add_cc_en", 32'(cc_en),     32'h1);
        check("add_wr",    32'(reg_write), 32'h1);
        check("add_opB",   32'(opB_mux_sel), 32'h0);
        check("add_alu",   32'(alu_func),  32'h0);
        tick();
        #1;
        check("add_back_fetch", 32'(state), 32'h0);

        // LD r4,[r5+#2] with three wait states
        ir = 16'hD4A2;
        tick();
        #1;
        check("ld_exec_state", 32'(state),       32'h1);
        check("ld_exec_wr",    32'(reg_write),   32'h0);
        check("ld_exec_cc",    32'(cc_en),       32'h0);
        check("ld_exec_opB",   32'(opB_mux_sel), 32'h1);
        check("ld_exec_ext",   32'(ext_op),      32'h1);
        check("ld_exec_srcA",  32'(srcA),        32'h5);
        mem_ack = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_wait_state", 32'(state),     32'h2);
            check("ld_wait_ren",   32'(mem_ren),   32'h1);
            check("ld_wait_nowr",  32'(reg_write), 32'h0);
            tick();
        end
        mem_ack = 1'b1;
        #1;
        check("ld_ack_ren",  32'(mem_ren),   32'h1);
        check("ld_ack_dest", 32'(dest),      32'h4);
        check("ld_ack_wr",   32'(reg_write), 32'h1);
        tick();
        #1;
        check("ld_back_fetch", 32'(state), 32'h0);

        // BEQ, taken then not taken
        ir = 16'hE705;
        cc = 4'b0100;
        tick();
        #1;
        check("beq_state",  32'(state),     32'h1);
        check("beq_taken",  32'(reg_write), 32'h1);
        check("beq_dest",   32'(dest),      32'h7);
        check("beq_srcA",   32'(srcA),      32'h7);
        check("beq_cc_en",  32'(cc_en),     32'h0);
        check("beq_alu",    32'(alu_func),  32'h7);
        cc = 4'b0000;
        #1;
        check("beq_nottaken", 32'(reg_write), 32'h0);
        check("beq_nt_cc_en", 32'(cc_en),     32'h0);
        tick();

        // Fetch timeout: terminal count reached with no ack
        mem_ack = 1'b0;
        #1;
        check("tmo_start_fetch", 32'(state), 32'h0);
        for (int i = 0; i < 15; i++) tick();
        #1;
        check("tmo_pre_err",  32'(bus_err),   32'h0);
        check("tmo_term_nowr", 32'(reg_write), 32'h0);
        check("tmo_term_noir", 32'(ir_load),   32'h0);
        tick();
        #1;
        check("tmo_bus_err", 32'(bus_err), 32'h1);
        check("tmo_state",   32'(state),   32'h0);
        check("tmo_nowr",    32'(reg_write), 32'h0);
        tick();
        #1;
        check("tmo_sticky", 32'(bus_err), 32'h1);

        // Ack in the terminal-count cycle wins over the timeout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_clr_bus_err", 32'(bus_err), 32'h0);
        for (int i = 0; i < 15; i++) tick();
        mem_ack = 1'b1;
        #1;
        check("term_ack_wr", 32'(reg_write), 32'h1);
        tick();
        #1;
        check("term_ack_no_err", 32'(bus_err), 32'h0);
        check("term_ack_state",  32'(state),   32'h1);
        tick();

        // Halt instruction
        ir = 16'hFFFF;
        tick();
        #1;
        check("halt_exec_state", 32'(state), 32'h1);
        check("halt_exec_en",    32'(en),    32'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            mem_ack = i[0];
            #1;
            check("halt_state", 32'(state), 32'h3);
            check("halt_en",    32'(en | 5'(flags)), 32'h0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("halt_rst_state", 32'(state), 32'h0);

        // ST r2,[r3] interrupted by reset while the ack is pending
        ir      = 16'hCA60;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        #1;
        check("st_state",  32'(state),     32'h2);
        check("st_wen",    32'(mem_wen),   32'h1);
        check("st_srcA",   32'(srcA),      32'h2);
        check("st_nowr",   32'(reg_write), 32'h0);
        rst = 1'b1;
        #1;
        check("st_rst_wen", 32'(mem_wen),   32'h0);
        check("st_rst_wr",  32'(reg_write), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("st_rst_state",   32'(state),   32'h0);
        check("st_rst_bus_err", 32'(bus_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
